// File: rtl/spram_arb.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a
// registered address; clears the whole RAM to INIT_VALUE after reset or on clr.
module spram_arb #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {INIT, ARB} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    ptr, ptr_nxt;   // 0: A wins a tie, 1: B wins a tie
  logic                    a_sel, b_sel;
  logic                    we_c, busy_c;
  logic [ADDR_WIDTH-1:0]   addr_c;
  logic [DATA_WIDTH-1:0]   data_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      ptr      <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      a_rvalid <= a_sel & ~a_we;
      b_rvalid <= b_sel & ~b_we;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    data_c    = '0;
    busy_c    = 1'b1;
    unique case (state)
      INIT: begin
        we_c   = 1'b1;
        addr_c = cnt;
        data_c = INIT_VALUE;
        if (clr) begin
          cnt_nxt = '0;
        end else if (cnt == '1) begin
          cnt_nxt   = '0;
          state_nxt = ARB;
        end else begin
          cnt_nxt = cnt + ADDR_WIDTH'(1);
        end
      end
      ARB: begin
        busy_c = 1'b0;
        if (clr) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end else begin
          a_sel = a_req & (~b_req | ~ptr);
          b_sel = b_req & (~a_req | ptr);
          if (a_sel) begin
            we_c    = a_we;
            addr_c  = a_addr;
            data_c  = a_wdata;
            ptr_nxt = 1'b1;
          end else if (b_sel) begin
            we_c    = b_we;
            addr_c  = b_addr;
            data_c  = b_wdata;
            ptr_nxt = 1'b0;
          end
        end
      end
    endcase
  end

  // RAM-side outputs are forced quiet while reset is held, independent of state.
  assign busy     = ~rst_n | busy_c;
  assign a_gnt    = rst_n & a_sel;
  assign b_gnt    = rst_n & b_sel;
  assign ram_we   = rst_n & we_c;
  assign ram_addr = rst_n ? addr_c : '0;
  assign ram_data = rst_n ? data_c : '0;
  assign a_rdata  = ram_q;
  assign b_rdata  = ram_q;

endmodule

// File: tb/tb_spram_arb.sv
// Directed bench for spram_arb: a behavioural RAM, a shadow-memory reference
// model checked every cycle, and literal expectations per scenario.
module tb_spram_arb;

  localparam int          AW    = 6;
  localparam int          DW    = 8;
  localparam int          DEPTH = 64;
  localparam logic [7:0]  IV    = 8'h00;

  logic          clk, rst_n, clr, busy;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;

  int n_vec = 0;
  int n_err = 0;

  spram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(IV)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-address single-port RAM
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] addr_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    addr_q <= ram_addr;
  end
  assign ram_q = mem[addr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining init writes, whose turn a tie is, shadow RAM,
  // and the read result owed to each requester next cycle.
  int            init_left, init_addr;
  bit            turn_b;
  bit            pend_a, pend_b;
  logic [DW-1:0] pend_a_d, pend_b_d;
  logic [DW-1:0] shadow [DEPTH];
  logic          e_busy, e_ag, e_bg, e_we, win_a, win_b;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  initial forever begin
    @(negedge clk);
    e_busy = 1'b1; e_ag = 1'b0; e_bg = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
    if (!rst_n) begin
      chk("m_rst_rvalid_a", 32'(a_rvalid), 0);
      chk("m_rst_rvalid_b", 32'(b_rvalid), 0);
      init_left = DEPTH; init_addr = 0; turn_b = 1'b0; pend_a = 1'b0; pend_b = 1'b0;
    end else begin
      chk("m_rvalid_a", 32'(a_rvalid), 32'(pend_a));
      chk("m_rvalid_b", 32'(b_rvalid), 32'(pend_b));
      if (pend_a) chk("m_rdata_a", 32'(a_rdata), 32'(pend_a_d));
      if (pend_b) chk("m_rdata_b", 32'(b_rdata), 32'(pend_b_d));
      pend_a = 1'b0; pend_b = 1'b0;
      if (init_left > 0) begin
        e_we = 1'b1; e_addr = AW'(init_addr); e_data = IV;
        shadow[init_addr] = IV;
        if (clr) begin init_left = DEPTH; init_addr = 0; end
        else begin init_left--; init_addr++; end
      end else begin
        e_busy = 1'b0;
        if (clr) begin
          init_left = DEPTH; init_addr = 0;
        end else begin
          win_a = a_req && (!b_req || !turn_b);
          win_b = b_req && !win_a;
          if (win_a) begin
            e_ag = 1'b1; e_we = a_we; e_addr = a_addr; e_data = a_wdata; turn_b = 1'b1;
            if (a_we) shadow[a_addr] = a_wdata;
            else begin pend_a = 1'b1; pend_a_d = shadow[a_addr]; end
          end else if (win_b) begin
            e_bg = 1'b1; e_we = b_we; e_addr = b_addr; e_data = b_wdata; turn_b = 1'b0;
            if (b_we) shadow[b_addr] = b_wdata;
            else begin pend_b = 1'b1; pend_b_d = shadow[b_addr]; end
          end
        end
      end
    end
    chk("m_busy", 32'(busy), 32'(e_busy));
    chk("m_a_gnt", 32'(a_gnt), 32'(e_ag));
    chk("m_b_gnt", 32'(b_gnt), 32'(e_bg));
    chk("m_ram_we", 32'(ram_we), 32'(e_we));
    chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("m_ram_data", 32'(ram_data), 32'(e_data));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_req = req; a_we = we; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_req = req; b_we = we; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
  endtask

  // Counts busy cycles from the next sample point, checking the address walk.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      sample();
      if (!busy) break;
      chk({name, "_addr"}, 32'(ram_addr), n);
      n++;
    end
    chk(name, n, DEPTH);
    tick();
  endtask

  task automatic wait_addr(input logic [AW-1:0] target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      sample();
      if (busy && ram_addr == target) hit = 1'b1;
    end
    chk("wait_addr", 32'(hit), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    rst_n = 1'b0; clr = 1'b0; idle();
    repeat (3) @(posedge clk);
    sample();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    tick();
    rst_n = 1'b1;
    wait_init("init_len");

    // Both requesting: A, B, A, B; all reads of an initialised RAM
    set_a(1'b1, 1'b0, 6'd10, 8'h00);
    set_b(1'b1, 1'b0, 6'd63, 8'h00);
    for (int i = 0; i < 4; i++) begin
      sample();
      got = a_gnt ? 0 : (b_gnt ? 1 : 2);
      chk("rr_order", got, i % 2);
      if (i > 0) chk("rr_rdata_zero", 32'(a_rvalid ? a_rdata : b_rdata), 0);
      tick();
      if (got == 0) set_a(1'b1, 1'b0, 6'd0, 8'h00);
      else if (got == 1) set_b(1'b1, 1'b0, 6'd5, 8'h00);
    end
    idle();

    // A writes 0x5A to 3, B reads it back the next cycle
    set_a(1'b1, 1'b1, 6'd3, 8'h5A);
    sample();
    chk("wr_a_gnt", 32'(a_gnt), 1);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b0, 6'd3, 8'h00);
    sample();
    chk("rd_b_gnt", 32'(b_gnt), 1);
    chk("wr_no_rvalid", 32'(a_rvalid), 0);
    tick();
    idle();
    sample();
    chk("rd_b_rvalid", 32'(b_rvalid), 1);
    chk("rd_b_rdata", 32'(b_rdata), 32'h5A);
    chk("rd_a_rvalid", 32'(a_rvalid), 0);
    tick();

    // Only B for three cycles, then a tie goes to A
    for (int i = 0; i < 3; i++) begin
      set_b(1'b1, 1'b1, 6'(40 + i), 8'(33 + i));
      sample();
      chk("b_only_gnt", 32'({a_gnt, b_gnt}), 1);
      tick();
    end
    set_a(1'b1, 1'b0, 6'd40, 8'h00);
    set_b(1'b1, 1'b0, 6'd41, 8'h00);
    sample();
    chk("tie_after_b", 32'({a_gnt, b_gnt}), 2);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    sample();
    chk("b_after_tie", 32'(b_gnt), 1);
    chk("rd40_data", 32'(a_rdata), 32'h21);
    tick();
    idle();
    sample();
    chk("rd41_data", 32'(b_rdata), 32'h22);
    tick();

    // clr beats a request, then full re-init and readback
    clr = 1'b1;
    set_a(1'b1, 1'b1, 6'd9, 8'hFF);
    sample();
    chk("clr_no_gnt", 32'(a_gnt), 0);
    tick();
    clr = 1'b0; idle();
    wait_init("clr_init_len");
    for (int k = 0; k < DEPTH; k++) begin
      set_a(1'b1, 1'b0, 6'(k), 8'h00);
      tick();
    end
    set_a(1'b1, 1'b0, 6'd9, 8'h00);
    tick();
    idle();
    sample();
    chk("rd9_after_clr", 32'(a_rdata), 32'(IV));
    tick();

    // clr during INIT restarts the walk at 0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_addr(6'd9);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    sample();
    chk("clr_in_init_addr", 32'(ram_addr), 0);

    // Reset pulsed at init address 20
    wait_addr(6'd20);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(ram_we), 0);
    chk("rst_mid_busy", 32'(busy), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("rst_init_len");

    // Write then immediate read-after-write of the same address
    set_a(1'b1, 1'b1, 6'd5, 8'h77);
    tick();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b0, 6'd5, 8'h00);
    tick();
    idle();
    sample();
    chk("raw_rdata", 32'(b_rdata), 32'h77);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
